// File: rtl/rx_decimator.sv
// rx_decimator
//   Block-average decimator with a first-word-fall-through output FIFO.
//   One input sample is captured per SAMPLE_PERIOD clocks, when the phase
//   counter equals CAPTURE_PHASE. Each group of DECIM = 2^LOG2_DECIM
//   captures is summed and divided by DECIM with an arithmetic shift, which
//   rounds toward negative infinity. The result enters the FIFO one clock
//   after the last capture of the group.
//
// Ports
//   crx_clk          in   sole clock, rising edge
//   rrx_rst_n        in   asynchronous assert, synchronised release, active low
//   erx_en           in   enable; low clears all non-reset state on the next edge
//   ifiltered_sample in   16-bit signed filtered input sample
//   iready           in   downstream ready; pops the FIFO head when ovalid is high
//   odata            out  16-bit signed FIFO head, 0 when the FIFO is empty
//   ovalid           out  FIFO non-empty
//   ooverflow        out  sticky: a result was dropped because the FIFO was full
//   ofifo_count      out  FIFO occupancy, 0..FIFO_DEPTH
module rx_decimator #(
  parameter int SAMPLE_PERIOD = 128,
  parameter int CAPTURE_PHASE = 1,
  parameter int LOG2_DECIM    = 2,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                         crx_clk,
  input  logic                         rrx_rst_n,
  input  logic                         erx_en,
  input  logic [15:0]                  ifiltered_sample,
  input  logic                         iready,
  output logic [15:0]                  odata,
  output logic                         ovalid,
  output logic                         ooverflow,
  output logic [$clog2(FIFO_DEPTH):0]  ofifo_count
);

  localparam int PW    = $clog2(SAMPLE_PERIOD);
  localparam int CW    = LOG2_DECIM;
  localparam int AW    = 16 + LOG2_DECIM;
  localparam int FW    = $clog2(FIFO_DEPTH);
  localparam int DECIM = 1 << LOG2_DECIM;

  localparam logic [PW-1:0] PHASE_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] PHASE_CAPT  = PW'(CAPTURE_PHASE);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DECIM - 1);
  localparam logic [FW:0]   COUNT_FULL  = (FW + 1)'(FIFO_DEPTH);

  // Reset release is registered so that the edge which releases reset does
  // not advance any state; counting starts on the edge after that.
  logic rst_sync_reg;
  logic active;

  logic [PW-1:0]        phase_reg;
  logic [CW-1:0]        cnt_reg;
  logic signed [AW-1:0] acc_reg;
  logic signed [AW-1:0] sample_ext;
  logic signed [AW-1:0] sum_next;
  logic [15:0]          block_result;
  logic [15:0]          result_reg;
  logic                 pending_reg;
  logic                 capture;
  logic                 capture_last;

  logic [15:0]  mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr_reg;
  logic [FW-1:0] rd_ptr_reg;
  logic [FW:0]   count_reg;
  logic [FW:0]   count_next;
  logic          overflow_reg;
  logic          full;
  logic          nonempty;
  logic          pop;
  logic          push;
  logic          drop;

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      rst_sync_reg <= 1'b0;
    end else begin
      rst_sync_reg <= 1'b1;
    end
  end

  assign active = rst_sync_reg && erx_en;

  // Phase counter: 0 in the first enabled cycle, wraps at SAMPLE_PERIOD-1.
  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      phase_reg <= '0;
    end else if (!active) begin
      phase_reg <= '0;
    end else if (phase_reg == PHASE_LAST) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_reg + PW'(1);
    end
  end

  assign capture      = active && (phase_reg == PHASE_CAPT);
  assign capture_last = capture && (cnt_reg == CNT_LAST);

  // Sign-extended sample and running sum; the accumulator is exactly wide
  // enough for DECIM full-scale samples, so no saturation is required.
  assign sample_ext = AW'($signed(ifiltered_sample));
  assign sum_next   = acc_reg + sample_ext;
  // Dropping the low LOG2_DECIM bits of the signed sum is the arithmetic
  // right shift; the remaining 16 bits always fit the output range.
  assign block_result = sum_next[AW-1:LOG2_DECIM];

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      acc_reg     <= '0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      pending_reg <= 1'b0;
    end else if (!active) begin
      acc_reg     <= '0;
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
    end else begin
      pending_reg <= capture_last;
      if (capture_last) begin
        result_reg <= block_result;
        acc_reg    <= '0;
        cnt_reg    <= '0;
      end else if (capture) begin
        acc_reg <= sum_next;
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  // FIFO control. A push into a full FIFO only succeeds when the head is
  // popped on the same edge; otherwise the result is dropped.
  assign nonempty = (count_reg != '0);
  assign full     = (count_reg == COUNT_FULL);
  assign pop      = active && nonempty && iready;
  assign push     = active && pending_reg && (!full || pop);
  assign drop     = active && pending_reg && full && !pop;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (FW + 1)'(1);
      2'b01:   count_next = count_reg - (FW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (!active) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + FW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + FW'(1);
      end
      count_reg <= count_next;
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Storage has no reset; occupancy alone decides what is visible.
  always_ff @(posedge crx_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= result_reg;
    end
  end

  assign ovalid      = nonempty;
  assign odata       = nonempty ? mem[rd_ptr_reg] : 16'd0;
  assign ooverflow   = overflow_reg;
  assign ofifo_count = count_reg;

endmodule

// File: tb/tb_rx_decimator.sv
// tb_rx_decimator
//   Self-checking bench for rx_decimator at default parameters. Expected
//   block results are queued when the last sample of a block is driven and
//   compared against odata whenever the DUT pops its FIFO head.
module tb_rx_decimator;

  localparam int SP = 128;

  logic        crx_clk = 1'b0;
  logic        rrx_rst_n;
  logic        erx_en;
  logic [15:0] ifiltered_sample;
  logic        iready;
  logic [15:0] odata;
  logic        ovalid;
  logic        ooverflow;
  logic [3:0]  ofifo_count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic seen_valid;

  typedef struct packed {
    logic signed [15:0] s0;
    logic signed [15:0] s1;
    logic signed [15:0] s2;
    logic signed [15:0] s3;
    logic signed [15:0] res;
  } vec_t;

  vec_t vecs [7];

  always #5 crx_clk = ~crx_clk;

  rx_decimator dut (
    .crx_clk          (crx_clk),
    .rrx_rst_n        (rrx_rst_n),
    .erx_en           (erx_en),
    .ifiltered_sample (ifiltered_sample),
    .iready           (iready),
    .odata            (odata),
    .ovalid           (ovalid),
    .ooverflow        (ooverflow),
    .ofifo_count      (ofifo_count)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge (scoreboard pop if a transfer is
  // happening), then advance to 1 time unit after the rising edge.
  task automatic tick();
    int e;
    int got;
    @(negedge crx_clk);
    seen_valid = ovalid;
    if (ovalid && iready && erx_en && rrx_rst_n) begin
      checks++;
      got = int'($signed(odata));
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_pop: odata=%0d popped with no expected entry", got);
      end else begin
        e = exp_q.pop_front();
        if (got != e) begin
          errors++;
          $display("FAIL sb_pop: odata=%0d expected %0d", got, e);
        end else begin
          $display("pop odata=%0d", got);
        end
      end
    end
    @(posedge crx_clk);
    #1;
  endtask

  task automatic feed(input logic signed [15:0] v);
    ifiltered_sample = v;
    repeat (SP) tick();
  endtask

  // Enable low for one edge, then high: the current cycle is phase 0.
  task automatic restart();
    erx_en = 1'b0;
    tick();
    erx_en = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
  endtask

  // Constant 100 block starting at phase 0; checks that ovalid appears two
  // clocks after the 4th capture cycle begins. Ends in the ovalid cycle.
  task automatic latency_check(input string name);
    exp_q.push_back(100);
    repeat (3) feed(16'sd100);
    tick();  // 4th capture cycle
    tick();  // push cycle
    check({name, "_valid_early"}, int'(ovalid), 0);
    tick();
    check({name, "_valid"}, int'(ovalid), 1);
    check({name, "_odata"}, int'($signed(odata)), 100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    vecs[0] = '{16'sd1, 16'sd2, 16'sd3, -16'sd7, -16'sd1};
    vecs[1] = '{16'sd3, 16'sd3, 16'sd3, 16'sd4, 16'sd3};
    vecs[2] = '{-16'sd8, -16'sd8, -16'sd8, -16'sd8, -16'sd8};
    vecs[3] = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};
    vecs[4] = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768};
    vecs[5] = '{16'sd5, 16'sd0, 16'sd0, 16'sd0, 16'sd1};
    vecs[6] = '{-16'sd5, 16'sd0, 16'sd0, 16'sd0, -16'sd2};

    rrx_rst_n        = 1'b0;
    erx_en           = 1'b0;
    iready           = 1'b0;
    ifiltered_sample = '0;
    repeat (3) tick();
    check("rst_odata", int'(odata), 0);
    check("rst_ovalid", int'(ovalid), 0);
    check("rst_overflow", int'(ooverflow), 0);
    check("rst_count", int'(ofifo_count), 0);
    rrx_rst_n = 1'b1;
    tick();

    // Constant input, latency and one pulse per 512 clocks.
    iready = 1'b1;
    restart();
    latency_check("const");
    exp_q.push_back(100);
    pulses = 0;
    for (int i = 0; i < 4 * SP; i++) begin
      tick();
      if (seen_valid) pulses++;
    end
    check("const_pulses_per_512", pulses, 1);
    tick();
    check("const_queue_empty", exp_q.size(), 0);

    // Table of blocks, back to back.
    restart();
    for (int i = 0; i < 7; i++) begin
      feed(vecs[i].s0);
      feed(vecs[i].s1);
      feed(vecs[i].s2);
      exp_q.push_back(int'(vecs[i].res));
      feed(vecs[i].s3);
    end
    drain("table_drain");

    // Overflow: 9 blocks with no consumer; only the first 8 are kept.
    iready = 1'b0;
    restart();
    for (int k = 0; k < 9; k++) begin
      if (k < 8) exp_q.push_back(10 * k + 5);
      repeat (4) feed(16'(10 * k + 5));
      if (k == 7) begin
        check("ovf_count_at_8", int'(ofifo_count), 8);
        check("ovf_flag_before", int'(ooverflow), 0);
      end
    end
    check("ovf_count_after_9", int'(ofifo_count), 8);
    check("ovf_flag_set", int'(ooverflow), 1);
    iready = 1'b1;
    repeat (8) tick();
    check("ovf_drained_valid", int'(ovalid), 0);
    check("ovf_flag_sticky", int'(ooverflow), 1);
    check("ovf_queue_empty", exp_q.size(), 0);

    // Enable low clears the overflow flag and the FIFO.
    iready = 1'b0;
    restart();
    check("en_clears_overflow", int'(ooverflow), 0);
    check("en_clears_count", int'(ofifo_count), 0);

    // Full FIFO with a pop on the push cycle: both succeed.
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(10 * k + 3);
      repeat (4) feed(16'(10 * k + 3));
    end
    check("full_count", int'(ofifo_count), 8);
    exp_q.push_back(777);
    repeat (3) feed(16'sd777);
    tick();  // capture cycle
    tick();  // push cycle
    iready = 1'b1;
    tick();
    iready = 1'b0;
    check("full_pushpop_count", int'(ofifo_count), 8);
    check("full_pushpop_overflow", int'(ooverflow), 0);
    iready = 1'b1;
    repeat (8) tick();
    check("full_drained_valid", int'(ovalid), 0);
    check("full_queue_empty", exp_q.size(), 0);

    // Enable dropped after two captures: partial sum discarded.
    restart();
    feed(16'sd1000);
    feed(16'sd1000);
    restart();
    exp_q.push_back(8);
    repeat (4) feed(16'sd8);
    drain("en_mid_block_drain");

    // Asynchronous reset mid-cycle with 3 results queued and a partial block.
    iready = 1'b0;
    restart();
    repeat (12) feed(16'sd50);
    feed(16'sd500);
    feed(16'sd500);
    check("pre_rst_count", int'(ofifo_count), 3);
    check("pre_rst_valid", int'(ovalid), 1);
    #2;
    rrx_rst_n = 1'b0;
    #1;
    check("async_rst_odata", int'(odata), 0);
    check("async_rst_valid", int'(ovalid), 0);
    check("async_rst_count", int'(ofifo_count), 0);
    check("async_rst_overflow", int'(ooverflow), 0);
    exp_q.delete();
    @(posedge crx_clk);
    #1;
    rrx_rst_n = 1'b1;
    tick();  // release edge: nothing advances
    iready = 1'b1;
    latency_check("post_rst");
    tick();
    check("post_rst_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
